// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution control blocks.
// Tap numbering: tap t of output row r reads input row r+t-1.
package conv_pkg;

  localparam int ADDR_W = 32;
  localparam int K_ROWS = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WRITE,
    DRAIN,
    DONE
  } conv_state_e;

  function automatic logic [1:0] first_tap(
    input int unsigned r
  );
    return (r == 0) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [1:0] last_tap(
    input int unsigned r,
    input int unsigned rows,
    input int unsigned k
  );
    return (r == rows - 1) ? 2'd1 : 2'(k - 1);
  endfunction

endpackage

// File: rtl/conv_row_sequencer_if.sv
// Host/config, distributor and aggregation-queue signals
// of the row sequencer.
interface conv_row_sequencer_if
  import conv_pkg::*;
#(
  parameter int AW = ADDR_W
);

  logic          start;
  logic          abort;
  logic [AW-1:0] in_base;
  logic [AW-1:0] filt_base;
  logic [AW-1:0] out_base;
  logic          ds_ready;
  logic [AW-1:0] filter_addr;
  logic          valid_filter;
  logic          filter_start_out;
  logic [AW-1:0] out_address;
  logic          valid_out_addr;
  logic [AW-1:0] in_output_addr;
  logic [AW-1:0] in_input_addr;
  logic          valid_inout;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, in_base, filt_base,
    output out_base, ds_ready,
    input  filter_addr, valid_filter,
    input  filter_start_out, out_address,
    input  valid_out_addr, in_output_addr,
    input  in_input_addr, valid_inout,
    input  busy, done
  );

  modport slave (
    input  start, abort, in_base, filt_base,
    input  out_base, ds_ready,
    output filter_addr, valid_filter,
    output filter_start_out, out_address,
    output valid_out_addr, in_output_addr,
    output in_input_addr, valid_inout,
    output busy, done
  );

endinterface

// File: rtl/conv_row_sequencer_tap_addr_gen.sv
// Combinational base + index * stride address generation
// for the filter, input-tap, output-row and row-centre addresses.
module tap_addr_gen #(
  parameter int AW         = 32,
  parameter int ROW_W      = 4,
  parameter int IN_STRIDE  = 1,
  parameter int OUT_STRIDE = 1
) (
  input  logic [AW-1:0]    in_base,
  input  logic [AW-1:0]    filt_base,
  input  logic [AW-1:0]    out_base,
  input  logic [ROW_W-1:0] row,
  input  logic [1:0]       tap,
  output logic [AW-1:0]    filter_addr,
  output logic [AW-1:0]    tap_addr,
  output logic [AW-1:0]    out_addr,
  output logic [AW-1:0]    centre_addr
);

  logic [AW-1:0] row_ext;
  logic [AW-1:0] tap_row;

  assign row_ext = AW'(row);
  // Never negative for an issued tap: out-of-range taps are skipped.
  assign tap_row = row_ext + AW'(tap) - AW'(1);

  assign filter_addr = filt_base + AW'(tap);
  assign tap_addr    = in_base + tap_row * AW'(IN_STRIDE);
  assign out_addr    = out_base + row_ext * AW'(OUT_STRIDE);
  assign centre_addr = in_base + row_ext * AW'(IN_STRIDE);

endmodule

// File: rtl/conv_row_sequencer.sv
// Row/tap sequencer for one 3x3 convolution pass with
// vertical zero padding by tap skipping.
module conv_row_sequencer
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_W,
  parameter int IMG_ROWS     = 16,
  parameter int K_ROWS       = conv_pkg::K_ROWS,
  parameter int IN_STRIDE    = 1,
  parameter int OUT_STRIDE   = 1,
  parameter int DRAIN_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  conv_row_sequencer_if.slave bus
);

  localparam int ROW_W =
    (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

  conv_state_e             state;
  logic [ROW_W-1:0]        row;
  logic [1:0]              tap;
  logic [DRN_W-1:0]        drn;
  logic [ADDR_WIDTH-1:0]   in_b;
  logic [ADDR_WIDTH-1:0]   filt_b;
  logic [ADDR_WIDTH-1:0]   out_b;
  logic [ADDR_WIDTH-1:0]   g_filt;
  logic [ADDR_WIDTH-1:0]   g_tap;
  logic [ADDR_WIDTH-1:0]   g_out;
  logic [ADDR_WIDTH-1:0]   g_ctr;
  logic                    last_row;
  logic [ROW_W-1:0]        row_nx;

  assign last_row = (row == ROW_W'(IMG_ROWS - 1));
  assign row_nx   = row + ROW_W'(1);

  tap_addr_gen #(
    .AW         (ADDR_WIDTH),
    .ROW_W      (ROW_W),
    .IN_STRIDE  (IN_STRIDE),
    .OUT_STRIDE (OUT_STRIDE)
  ) u_gen (
    .in_base     (in_b),
    .filt_base   (filt_b),
    .out_base    (out_b),
    .row         (row),
    .tap         (tap),
    .filter_addr (g_filt),
    .tap_addr    (g_tap),
    .out_addr    (g_out),
    .centre_addr (g_ctr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      row                  <= '0;
      tap                  <= '0;
      drn                  <= '0;
      in_b                 <= '0;
      filt_b               <= '0;
      out_b                <= '0;
      bus.filter_addr      <= '0;
      bus.valid_filter     <= 1'b0;
      bus.filter_start_out <= 1'b0;
      bus.out_address      <= '0;
      bus.valid_out_addr   <= 1'b0;
      bus.in_output_addr   <= '0;
      bus.in_input_addr    <= '0;
      bus.valid_inout      <= 1'b0;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
    end else begin
      // Valids are single-cycle pulses, re-armed only when issuing.
      bus.valid_filter     <= 1'b0;
      bus.valid_out_addr   <= 1'b0;
      bus.filter_start_out <= 1'b0;
      bus.valid_inout      <= 1'b0;
      bus.done             <= 1'b0;
      if (bus.abort && state != IDLE) begin
        state    <= IDLE;
        bus.busy <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              in_b     <= bus.in_base;
              filt_b   <= bus.filt_base;
              out_b    <= bus.out_base;
              row      <= '0;
              tap      <= first_tap(0);
              state    <= ISSUE;
              bus.busy <= 1'b1;
            end
          end
          ISSUE: begin
            if (bus.ds_ready) begin
              bus.valid_filter     <= 1'b1;
              bus.valid_out_addr   <= 1'b1;
              bus.filter_addr      <= g_filt;
              bus.out_address      <= g_tap;
              bus.filter_start_out <=
                (tap == first_tap(32'(row)));
              if (tap == last_tap(32'(row), IMG_ROWS, K_ROWS))
                state <= WRITE;
              else
                tap <= tap + 2'd1;
            end
          end
          WRITE: begin
            if (bus.ds_ready) begin
              bus.valid_inout    <= 1'b1;
              bus.in_output_addr <= g_out;
              bus.in_input_addr  <= g_ctr;
              if (last_row) begin
                drn   <= '0;
                state <= DRAIN;
              end else begin
                row   <= row_nx;
                tap   <= first_tap(32'(row_nx));
                state <= ISSUE;
              end
            end
          end
          DRAIN: begin
            if (drn == DRN_W'(DRAIN_CYCLES - 1))
              state <= DONE;
            else
              drn <= drn + DRN_W'(1);
          end
          DONE: begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Directed bench for conv_row_sequencer: three instances
// (4 rows, 1 row, 2 rows with input stride 2) behind one driver.
module tb_conv_row_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        ds_ready;
  logic [31:0] in_base;
  logic [31:0] filt_base;
  logic [31:0] out_base;
  int          sel;
  int          total;
  int          bad;

  always #5 clk = ~clk;

  conv_row_sequencer_if ifs [3] ();
  logic [133:0] obs [3];

  for (genvar g = 0; g < 3; g++) begin : g_drv
    assign ifs[g].start     = start && (sel == g);
    assign ifs[g].abort     = abort && (sel == g);
    assign ifs[g].ds_ready  = ds_ready;
    assign ifs[g].in_base   = in_base;
    assign ifs[g].filt_base = filt_base;
    assign ifs[g].out_base  = out_base;
    assign obs[g] = {
      ifs[g].valid_filter, ifs[g].valid_out_addr,
      ifs[g].valid_inout, ifs[g].filter_start_out,
      ifs[g].busy, ifs[g].done,
      ifs[g].filter_addr, ifs[g].out_address,
      ifs[g].in_output_addr, ifs[g].in_input_addr
    };
  end

  conv_row_sequencer #(.IMG_ROWS(4)) u_main (
    .clk (clk), .rst (rst), .bus (ifs[0].slave)
  );
  conv_row_sequencer #(.IMG_ROWS(1)) u_one (
    .clk (clk), .rst (rst), .bus (ifs[1].slave)
  );
  conv_row_sequencer #(
    .IMG_ROWS (2), .IN_STRIDE (2)
  ) u_wrap (
    .clk (clk), .rst (rst), .bus (ifs[2].slave)
  );

  logic        s_vf, s_vo, s_vio, s_fso, s_busy, s_done;
  logic [31:0] s_fa, s_ta, s_wa, s_ca;
  assign {s_vf, s_vo, s_vio, s_fso, s_busy, s_done,
          s_fa, s_ta, s_wa, s_ca} = obs[sel];

  localparam logic [31:0] E_IN [10] = '{
    32'h100, 32'h101, 32'h100, 32'h101, 32'h102,
    32'h101, 32'h102, 32'h103, 32'h102, 32'h103};
  localparam logic [31:0] E_FA [10] = '{
    32'h41, 32'h42, 32'h40, 32'h41, 32'h42,
    32'h40, 32'h41, 32'h42, 32'h40, 32'h41};
  localparam logic E_FSO [10] = '{
    1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
    1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  logic [31:0] q_in [$];
  logic [31:0] q_fa [$];
  logic [31:0] q_oa [$];
  logic [31:0] q_ia [$];
  logic        q_fso [$];
  logic        q_act [$];
  logic        q_busy [$];
  int          done_cyc;

  // Start a pass on instance dev and log every issued item;
  // sample k reflects the k-th clock edge after the start edge.
  task automatic run_pass(
    input int dev, input logic [31:0] bi, bf, bo,
    input int stall_at, stall_len, abort_at,
    input int mid_at, max_cyc
  );
    sel = dev;
    q_in.delete(); q_fa.delete(); q_oa.delete();
    q_ia.delete(); q_fso.delete(); q_act.delete();
    q_busy.delete();
    done_cyc = 0;
    in_base = bi; filt_base = bf; out_base = bo;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      ds_ready = !(k >= stall_at && k < stall_at + stall_len);
      abort = (k == abort_at);
      start = (k == mid_at);
      if (k == mid_at) begin
        in_base = 32'h900; filt_base = 32'h990;
        out_base = 32'h9900;
      end
      @(negedge clk);
      if (s_vo) begin
        q_in.push_back(s_ta);
        q_fso.push_back(s_fso);
      end
      if (s_vf) q_fa.push_back(s_fa);
      if (s_vio) begin
        q_oa.push_back(s_wa);
        q_ia.push_back(s_ca);
      end
      q_act.push_back(s_vf | s_vo | s_vio | s_done);
      q_busy.push_back(s_busy);
      if (s_done && done_cyc == 0) done_cyc = k;
      if (s_done && abort_at == 0) break;
    end
    start = 1'b0; abort = 1'b0; ds_ready = 1'b1;
  endtask

  task automatic test_reset;
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      total++;
      if ({s_vf, s_vo, s_vio, s_fso, s_busy, s_done} !== 6'b0) begin
        bad++;
        $display("FAIL reset_flags dev=%0d got=%b exp=000000", d,
                 {s_vf, s_vo, s_vio, s_fso, s_busy, s_done});
      end
      total++;
      if ((s_fa | s_ta | s_wa | s_ca) !== 32'h0) begin
        bad++;
        $display("FAIL reset_addr dev=%0d got=%h/%h/%h/%h exp=0",
                 d, s_fa, s_ta, s_wa, s_ca);
      end
    end
    sel = 0;
  endtask

  task automatic test_basic;
    run_pass(0, 32'h100, 32'h40, 32'h200, 0, 0, 0, 0, 40);
    total++;
    if (q_in.size() != 10 || q_fa.size() != 10) begin
      bad++;
      $display("FAIL basic_taps got=%0d/%0d exp=10/10",
               q_in.size(), q_fa.size());
    end
    for (int i = 0; i < q_in.size() && i < 10; i++) begin
      total++;
      if (q_in[i] !== E_IN[i] || q_fso[i] !== E_FSO[i]) begin
        bad++;
        $display("FAIL basic_in[%0d] got=%h/%b exp=%h/%b", i,
                 q_in[i], q_fso[i], E_IN[i], E_FSO[i]);
      end
    end
    for (int i = 0; i < q_fa.size() && i < 10; i++) begin
      total++;
      if (q_fa[i] !== E_FA[i]) begin
        bad++;
        $display("FAIL basic_filt[%0d] got=%h exp=%h", i,
                 q_fa[i], E_FA[i]);
      end
    end
    total++;
    if (q_oa.size() != 4) begin
      bad++;
      $display("FAIL basic_push_count got=%0d exp=4", q_oa.size());
    end
    for (int i = 0; i < q_oa.size() && i < 4; i++) begin
      total++;
      if (q_oa[i] !== 32'h200 + i || q_ia[i] !== 32'h100 + i) begin
        bad++;
        $display("FAIL basic_push[%0d] got=%h/%h exp=%h/%h", i,
                 q_oa[i], q_ia[i], 32'h200 + i, 32'h100 + i);
      end
    end
    total++;
    if (done_cyc != 17) begin
      bad++;
      $display("FAIL basic_done got=%0d exp=17", done_cyc);
    end
  endtask

  task automatic test_backpressure;
    run_pass(0, 32'h100, 32'h40, 32'h200, 5, 3, 0, 0, 40);
    total++;
    if (q_in.size() != 10) begin
      bad++;
      $display("FAIL bp_taps got=%0d exp=10", q_in.size());
    end
    for (int i = 0; i < q_in.size() && i < 10; i++) begin
      total++;
      if (q_in[i] !== E_IN[i] || q_fa[i] !== E_FA[i]) begin
        bad++;
        $display("FAIL bp_seq[%0d] got=%h/%h exp=%h/%h", i,
                 q_in[i], q_fa[i], E_IN[i], E_FA[i]);
      end
    end
    for (int k = 5; k <= 7 && k <= q_act.size(); k++) begin
      total++;
      if (q_act[k-1] !== 1'b0) begin
        bad++;
        $display("FAIL bp_stall_valid cyc=%0d got=%b exp=0", k,
                 q_act[k-1]);
      end
    end
    total++;
    if (done_cyc != 20) begin
      bad++;
      $display("FAIL bp_done got=%0d exp=20", done_cyc);
    end
  endtask

  task automatic test_abort;
    run_pass(0, 32'h100, 32'h40, 32'h200, 0, 0, 11, 0, 30);
    total++;
    if (q_busy[9] !== 1'b1 || q_busy[10] !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy got=%b%b exp=10",
               q_busy[9], q_busy[10]);
    end
    total++;
    if (q_act[10] !== 1'b0) begin
      bad++;
      $display("FAIL abort_valid got=%b exp=0", q_act[10]);
    end
    total++;
    if (done_cyc != 0 || q_oa.size() != 2 || q_in.size() != 8) begin
      bad++;
      $display("FAIL abort_counts got=%0d/%0d/%0d exp=0/2/8",
               done_cyc, q_oa.size(), q_in.size());
    end
    run_pass(0, 32'h300, 32'h80, 32'h500, 0, 0, 0, 0, 40);
    total++;
    if (q_in.size() < 1 || q_in[0] !== 32'h300 ||
        q_fa[0] !== 32'h81 || q_oa.size() < 1 ||
        q_oa[0] !== 32'h500) begin
      bad++;
      $display("FAIL abort_restart got=%h/%h/%h exp=300/81/500",
               q_in[0], q_fa[0], q_oa[0]);
    end
    total++;
    if (done_cyc != 17) begin
      bad++;
      $display("FAIL abort_restart_done got=%0d exp=17", done_cyc);
    end
  endtask

  task automatic test_start_busy;
    run_pass(0, 32'h100, 32'h40, 32'h200, 0, 0, 0, 5, 40);
    total++;
    if (q_in.size() != 10) begin
      bad++;
      $display("FAIL sbusy_taps got=%0d exp=10", q_in.size());
    end
    for (int i = 0; i < q_in.size() && i < 10; i++) begin
      total++;
      if (q_in[i] !== E_IN[i] || q_fa[i] !== E_FA[i]) begin
        bad++;
        $display("FAIL sbusy_seq[%0d] got=%h/%h exp=%h/%h", i,
                 q_in[i], q_fa[i], E_IN[i], E_FA[i]);
      end
    end
    total++;
    if (q_oa.size() != 4 || q_oa[3] !== 32'h203 ||
        done_cyc != 17) begin
      bad++;
      $display("FAIL sbusy_end got=%0d/%h/%0d exp=4/203/17",
               q_oa.size(), q_oa[3], done_cyc);
    end
  endtask

  task automatic test_async_reset;
    sel = 0;
    in_base = 32'h100; filt_base = 32'h40; out_base = 32'h200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if (s_vf !== 1'b1 || s_ta !== 32'h100) begin
      bad++;
      $display("FAIL arst_pre got=%b/%h exp=1/100", s_vf, s_ta);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({s_vf, s_vo, s_vio, s_fso, s_busy, s_done} !== 6'b0 ||
        (s_fa | s_ta) !== 32'h0) begin
      bad++;
      $display("FAIL arst_clear got=%b/%h/%h exp=0/0/0",
               {s_vf, s_vo, s_vio, s_fso, s_busy, s_done},
               s_fa, s_ta);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({s_vf, s_vo, s_vio, s_busy, s_done} !== 5'b0) begin
        bad++;
        $display("FAIL arst_idle cyc=%0d got=%b exp=00000", k,
                 {s_vf, s_vo, s_vio, s_busy, s_done});
      end
    end
  endtask

  task automatic test_one_row;
    run_pass(1, 32'hFFFF_FFFF, 32'h10, 32'h20, 0, 0, 0, 0, 20);
    total++;
    if (q_in.size() != 1 || q_in[0] !== 32'hFFFF_FFFF ||
        q_fa[0] !== 32'h11 || q_fso[0] !== 1'b1) begin
      bad++;
      $display("FAIL one_tap got=%0d/%h/%h/%b exp=1/ffffffff/11/1",
               q_in.size(), q_in[0], q_fa[0], q_fso[0]);
    end
    total++;
    if (q_oa.size() != 1 || q_oa[0] !== 32'h20 ||
        q_ia[0] !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL one_push got=%0d/%h/%h exp=1/20/ffffffff",
               q_oa.size(), q_oa[0], q_ia[0]);
    end
    total++;
    if (done_cyc != 5) begin
      bad++;
      $display("FAIL one_done got=%0d exp=5", done_cyc);
    end
  endtask

  task automatic test_stride_wrap;
    logic [31:0] e_w [4];
    e_w = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFE, 32'h0};
    run_pass(2, 32'hFFFF_FFFE, 32'h0, 32'h40, 0, 0, 0, 0, 30);
    total++;
    if (q_in.size() != 4) begin
      bad++;
      $display("FAIL wrap_taps got=%0d exp=4", q_in.size());
    end
    for (int i = 0; i < q_in.size() && i < 4; i++) begin
      total++;
      if (q_in[i] !== e_w[i]) begin
        bad++;
        $display("FAIL wrap_in[%0d] got=%h exp=%h", i,
                 q_in[i], e_w[i]);
      end
    end
    total++;
    if (q_oa.size() != 2 || q_oa[1] !== 32'h41 ||
        q_ia[0] !== 32'hFFFF_FFFE || q_ia[1] !== 32'h0) begin
      bad++;
      $display("FAIL wrap_push got=%0d/%h/%h/%h exp=2/41/fffffffe/0",
               q_oa.size(), q_oa[1], q_ia[0], q_ia[1]);
    end
    total++;
    if (done_cyc != 9) begin
      bad++;
      $display("FAIL wrap_done got=%0d exp=9", done_cyc);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; ds_ready = 1'b1;
    sel = 0; in_base = '0; filt_base = '0; out_base = '0;
    total = 0; bad = 0;
    #2 rst = 1'b1;
    @(negedge clk);
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_basic;
    test_backpressure;
    test_abort;
    test_start_busy;
    test_async_reset;
    test_one_row;
    test_stride_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
